// File: rtl/spu_addsub_pipe.sv
// rtl/spu_addsub_pipe.sv - multi-lane add/sub pipeline with saturation, overflow flags and event counters
module spu_addsub_pipe #(
   parameter int LANES      = 4,
   parameter int DATA_BITS  = 8,
   parameter int LATENCY    = 2,
   parameter int COUNT_BITS = 16
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           cke,
   input  logic [5:0]                     s_cfg,
   input  logic [LANES*DATA_BITS-1:0]     s_data0,
   input  logic [LANES*DATA_BITS-1:0]     s_data1,
   input  logic                           s_valid,
   output logic                           s_ready,
   output logic [LANES*DATA_BITS-1:0]     m_data,
   output logic [LANES-1:0]               m_carry,
   output logic [LANES-1:0]               m_ovf,
   output logic                           m_valid,
   input  logic                           m_ready,
   input  logic                           clear,
   output logic [LANES-1:0]               ovf_sticky,
   output logic [COUNT_BITS-1:0]          sat_count
);

   localparam int W = LANES * DATA_BITS;
   // Three guard bits cover the widest case (a +/- 2b + carry-in) in both interpretations.
   localparam int E = DATA_BITS + 3;
   localparam logic [DATA_BITS-1:0] SMAX = {1'b0, {(DATA_BITS-1){1'b1}}};
   localparam logic [DATA_BITS-1:0] SMIN = {1'b1, {(DATA_BITS-1){1'b0}}};
   localparam logic [E-1:0]         ONE  = {{(E-1){1'b0}}, 1'b1};

   // Returns {clamped, ovf, carry, result} for one lane.
   function automatic logic [DATA_BITS+2:0] f_lane(
      input logic [DATA_BITS-1:0] a,
      input logic [DATA_BITS-1:0] b,
      input logic [5:0]           cfg
   );
      logic [E-1:0]         au, bu, as_e, bs_e, ru, rs, cin;
      logic                 cy, ov, cl;
      logic [DATA_BITS-1:0] res;
      au   = {3'b000, a};
      bu   = {3'b000, b};
      as_e = {{3{a[DATA_BITS-1]}}, a};
      bs_e = {{3{b[DATA_BITS-1]}}, b};
      cin  = {{(E-1){1'b0}}, cfg[3]};
      case (cfg[2:0])
         3'd0:    begin ru = au + bu;        rs = as_e + bs_e;        end
         3'd1:    begin ru = au - bu;        rs = as_e - bs_e;        end
         3'd2:    begin ru = au - ONE;       rs = as_e - ONE;         end
         3'd3:    begin ru = au + ONE;       rs = as_e + ONE;         end
         3'd4:    begin ru = au + au;        rs = as_e + as_e;        end
         3'd5:    begin ru = au - au;        rs = as_e - as_e;        end
         3'd6:    begin ru = au + (bu << 1); rs = as_e + (bs_e << 1); end
         default: begin ru = au - (bu << 1); rs = as_e - (bs_e << 1); end
      endcase
      ru = ru + cin;
      rs = rs + cin;
      // Unsigned range exceeded when any guard bit is set; signed when guard bits and MSB disagree.
      cy = |ru[E-1:DATA_BITS];
      ov = !((&rs[E-1:DATA_BITS-1]) || !(|rs[E-1:DATA_BITS-1]));
      // Both sums share the same low bits; pick per mode so each is consumed.
      res = cfg[4] ? rs[DATA_BITS-1:0] : ru[DATA_BITS-1:0];
      cl  = 1'b0;
      if (cfg[5:4] == 2'b01 && ov) begin
         cl  = 1'b1;
         res = rs[E-1] ? SMIN : SMAX;
      end else if (cfg[5:4] == 2'b10 && cy) begin
         cl  = 1'b1;
         res = ru[E-1] ? '0 : '1;
      end
      return {cl, ov, cy, res};
   endfunction

   logic [W-1:0]        w_res;
   logic [LANES-1:0]    w_cy, w_ov, w_cl;
   logic                w_stall, w_adv, w_acc, w_hs, w_any_cl;
   logic [COUNT_BITS-1:0] w_cnt_base;

   logic [LATENCY-1:0]  r_vld;
   logic [LATENCY-1:0]  r_cl;
   logic [W-1:0]        r_data [LATENCY];
   logic [LANES-1:0]    r_cy   [LATENCY];
   logic [LANES-1:0]    r_ov   [LATENCY];
   logic [LANES-1:0]    r_sticky;
   logic [COUNT_BITS-1:0] r_cnt;

   // Per-lane arithmetic on the incoming beat.
   always_comb begin
      w_res = '0;
      w_cy  = '0;
      w_ov  = '0;
      w_cl  = '0;
      for (int i = 0; i < LANES; i++) begin
         {w_cl[i], w_ov[i], w_cy[i], w_res[i*DATA_BITS +: DATA_BITS]} =
            f_lane(s_data0[i*DATA_BITS +: DATA_BITS], s_data1[i*DATA_BITS +: DATA_BITS], s_cfg);
      end
   end

   // The whole pipeline moves as one; a stalled output freezes every stage so bubbles are kept.
   assign w_stall  = r_vld[LATENCY-1] && !m_ready;
   assign w_adv    = cke && !w_stall;
   assign s_ready  = reset && w_adv;
   assign w_acc    = s_valid && s_ready;
   assign w_any_cl = |w_cl;

   // Pipeline stage registers: stage 0 captures the computed beat, later stages shift.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_vld <= '0;
         r_cl  <= '0;
         for (int k = 0; k < LATENCY; k++) begin
            r_data[k] <= '0;
            r_cy[k]   <= '0;
            r_ov[k]   <= '0;
         end
      end else if (w_adv) begin
         r_vld[0]  <= w_acc;
         r_cl[0]   <= w_any_cl;
         r_data[0] <= w_res;
         r_cy[0]   <= w_cy;
         r_ov[0]   <= w_ov;
         for (int k = 1; k < LATENCY; k++) begin
            r_vld[k]  <= r_vld[k-1];
            r_cl[k]   <= r_cl[k-1];
            r_data[k] <= r_data[k-1];
            r_cy[k]   <= r_cy[k-1];
            r_ov[k]   <= r_ov[k-1];
         end
      end
   end

   assign m_valid = r_vld[LATENCY-1];
   assign m_data  = r_data[LATENCY-1];
   assign m_carry = r_cy[LATENCY-1];
   assign m_ovf   = r_ov[LATENCY-1];

   assign w_hs       = cke && m_valid && m_ready;
   assign w_cnt_base = clear ? '0 : r_cnt;

   // Sticky overflow and saturated-beat counter; a handshake wins over a coincident clear.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_sticky <= '0;
         r_cnt    <= '0;
      end else if (cke) begin
         r_sticky <= (clear ? '0 : r_sticky) | (w_hs ? m_ovf : '0);
         if (w_hs && r_cl[LATENCY-1] && w_cnt_base != '1)
            r_cnt <= w_cnt_base + COUNT_BITS'(1);
         else
            r_cnt <= w_cnt_base;
      end
   end

   assign ovf_sticky = r_sticky;
   assign sat_count  = r_cnt;

endmodule

// File: tb/tb_spu_addsub_pipe.sv
// tb/tb_spu_addsub_pipe.sv - scoreboard testbench for spu_addsub_pipe
module tb_spu_addsub_pipe;

   localparam int LANES = 4;
   localparam int D     = 8;
   localparam int LAT   = 2;
   localparam int CB    = 16;
   localparam int W     = LANES * D;

   logic             clk = 1'b0;
   logic             reset, cke, s_valid, s_ready, m_valid, m_ready, clear;
   logic [5:0]       s_cfg;
   logic [W-1:0]     s_data0, s_data1, m_data;
   logic [LANES-1:0] m_carry, m_ovf, ovf_sticky;
   logic [CB-1:0]    sat_count;

   always #5 clk = ~clk;

   spu_addsub_pipe #(.LANES(LANES), .DATA_BITS(D), .LATENCY(LAT), .COUNT_BITS(CB)) u_dut (
      .clk(clk), .reset(reset), .cke(cke), .s_cfg(s_cfg), .s_data0(s_data0), .s_data1(s_data1),
      .s_valid(s_valid), .s_ready(s_ready), .m_data(m_data), .m_carry(m_carry), .m_ovf(m_ovf),
      .m_valid(m_valid), .m_ready(m_ready), .clear(clear), .ovf_sticky(ovf_sticky), .sat_count(sat_count)
   );

   typedef struct {
      logic [W-1:0]     data;
      logic [LANES-1:0] cy;
      logic [LANES-1:0] ov;
      logic             cl;
   } exp_t;

   exp_t             q[$];
   exp_t             mon_e;
   int               n_cmp = 0, n_err = 0, n_out = 0;
   logic [LANES-1:0] exp_sticky = '0;
   logic [CB-1:0]    exp_cnt = '0;
   logic [W-1:0]     last_data = '0;
   logic [LANES-1:0] last_cy = '0, last_ov = '0;
   logic             prev_hold = 1'b0, hs, have_e;
   logic [40:0]      snap = '0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_cmp++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
      end
   endtask

   function automatic exp_t model(input logic [5:0] cfg, input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t       e;
      int         ua, ub, sa, sb, ru, rs;
      logic [7:0] d;
      e.data = '0; e.cy = '0; e.ov = '0; e.cl = 1'b0;
      for (int i = 0; i < LANES; i++) begin
         ua = {24'b0, a[i*D +: D]};
         ub = {24'b0, b[i*D +: D]};
         sa = {{24{a[i*D+D-1]}}, a[i*D +: D]};
         sb = {{24{b[i*D+D-1]}}, b[i*D +: D]};
         case (cfg[2:0])
            3'd0: begin ru = ua + ub;     rs = sa + sb;     end
            3'd1: begin ru = ua - ub;     rs = sa - sb;     end
            3'd2: begin ru = ua - 1;      rs = sa - 1;      end
            3'd3: begin ru = ua + 1;      rs = sa + 1;      end
            3'd4: begin ru = 2 * ua;      rs = 2 * sa;      end
            3'd5: begin ru = 0;           rs = 0;           end
            3'd6: begin ru = ua + 2 * ub; rs = sa + 2 * sb; end
            default: begin ru = ua - 2 * ub; rs = sa - 2 * sb; end
         endcase
         ru = ru + (cfg[3] ? 1 : 0);
         rs = rs + (cfg[3] ? 1 : 0);
         e.cy[i] = (ru < 0) || (ru > 255);
         e.ov[i] = (rs < -128) || (rs > 127);
         d = ru[7:0];
         if (cfg[5:4] == 2'b01 && e.ov[i]) begin
            d = (rs < 0) ? 8'h80 : 8'h7F;
            e.cl = 1'b1;
         end else if (cfg[5:4] == 2'b10 && e.cy[i]) begin
            d = (ru < 0) ? 8'h00 : 8'hFF;
            e.cl = 1'b1;
         end
         e.data[i*D +: D] = d;
      end
      return e;
   endfunction

   // Monitor: sample between edges, compare outputs, advance the status model, log accepted beats.
   always @(negedge clk) begin
      if (!reset) begin
         q.delete();
         exp_sticky = '0;
         exp_cnt    = '0;
         prev_hold  = 1'b0;
      end else begin
         check_eq("sat_count", 64'(sat_count), 64'(exp_cnt));
         check_eq("ovf_sticky", 64'(ovf_sticky), 64'(exp_sticky));
         if (prev_hold)
            check_eq("frozen_outputs", 64'({m_valid, m_data, m_carry, m_ovf}), 64'(snap));
         if (m_valid && !m_ready) check_eq("s_ready_stall", 64'(s_ready), 64'(0));
         if (!cke) check_eq("s_ready_cke", 64'(s_ready), 64'(0));
         hs     = cke && m_valid && m_ready;
         have_e = 1'b0;
         if (hs) begin
            if (q.size() == 0) begin
               check_eq("unexpected_beat", 64'(m_valid), 64'(0));
            end else begin
               mon_e  = q.pop_front();
               have_e = 1'b1;
               check_eq("m_data", 64'(m_data), 64'(mon_e.data));
               check_eq("m_carry", 64'(m_carry), 64'(mon_e.cy));
               check_eq("m_ovf", 64'(m_ovf), 64'(mon_e.ov));
               last_data = m_data;
               last_cy   = m_carry;
               last_ov   = m_ovf;
               n_out++;
            end
         end
         if (cke) begin
            exp_sticky = (clear ? '0 : exp_sticky) | (have_e ? mon_e.ov : '0);
            if (clear) exp_cnt = '0;
            if (have_e && mon_e.cl && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
         end
         prev_hold = !cke || (m_valid && !m_ready);
         snap      = {m_valid, m_data, m_carry, m_ovf};
         if (s_valid && s_ready) q.push_back(model(s_cfg, s_data0, s_data1));
      end
   end

   task automatic send_beat(input logic [5:0] cfg, input logic [W-1:0] a, input logic [W-1:0] b);
      bit got;
      int n;
      s_cfg = cfg; s_data0 = a; s_data1 = b; s_valid = 1'b1;
      got = 1'b0; n = 0;
      while (!got && n < 200) begin
         @(negedge clk);
         got = s_ready;
         @(posedge clk); #1;
         n++;
      end
      s_valid = 1'b0;
      if (!got) check_eq("accept_timeout", 64'(got), 64'(1));
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((q.size() != 0 || m_valid) && n < 300) begin
         @(posedge clk); #1;
         n++;
      end
      check_eq("drain_left", 64'(q.size()), 64'(0));
   endtask

   task automatic step(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   int n0, lat;

   initial begin
      reset = 1'b0; cke = 1'b1; m_ready = 1'b1; clear = 1'b0;
      s_valid = 1'b0; s_cfg = '0; s_data0 = '0; s_data1 = '0;
      step(2);
      check_eq("rst_m_valid", 64'(m_valid), 64'(0));
      check_eq("rst_m_data", 64'(m_data), 64'(0));
      check_eq("rst_flags", 64'({m_carry, m_ovf}), 64'(0));
      check_eq("rst_s_ready", 64'(s_ready), 64'(0));
      check_eq("rst_sat_count", 64'(sat_count), 64'(0));
      check_eq("rst_sticky", 64'(ovf_sticky), 64'(0));
      reset = 1'b1;
      step(1);

      // op0 wrap: F0+20 -> 10 with carry, and latency count
      send_beat(6'b00_0_000, {4{8'hF0}}, {4{8'h20}});
      lat = 1;
      while (!m_valid && lat < 10) begin @(posedge clk); #1; lat++; end
      check_eq("latency", 64'(lat), 64'(LAT));
      drain();
      check_eq("op0_data", 64'(last_data), 64'h10101010);
      check_eq("op0_carry", 64'(last_cy), 64'hF);
      check_eq("op0_ovf", 64'(last_ov), 64'h0);

      // op1 signed saturate on lane 0: 0x80-1 clamps to 0x80
      send_beat(6'b01_0_001, 32'h00000080, 32'h00000001);
      drain();
      check_eq("op1_data", 64'(last_data), 64'h00000080);
      check_eq("op1_ovf", 64'(last_ov), 64'h1);
      check_eq("op1_carry", 64'(last_cy), 64'h0);
      check_eq("op1_sat_count", 64'(sat_count), 64'd1);
      check_eq("op1_sticky", 64'(ovf_sticky), 64'h1);

      // op7 unsigned saturate with carry-in: 5-6+1=0 no clamp, 2-6+1 clamps to 0
      send_beat(6'b10_1_111, {4{8'h05}}, {4{8'h03}});
      drain();
      check_eq("op7a_data", 64'(last_data), 64'h0);
      check_eq("op7a_carry", 64'(last_cy), 64'h0);
      check_eq("op7a_sat_count", 64'(sat_count), 64'd1);
      send_beat(6'b10_1_111, {4{8'h02}}, {4{8'h03}});
      drain();
      check_eq("op7b_data", 64'(last_data), 64'h0);
      check_eq("op7b_carry", 64'(last_cy), 64'hF);
      check_eq("op7b_sat_count", 64'(sat_count), 64'd2);

      // plain clear
      clear = 1'b1; step(1); clear = 1'b0; step(1);
      check_eq("clear_sticky", 64'(ovf_sticky), 64'h0);
      check_eq("clear_count", 64'(sat_count), 64'd0);

      // clear coincident with an overflowing, saturated handshake on lane 2
      m_ready = 1'b0;
      send_beat(6'b01_0_000, 32'h007F0000, 32'h00010000);
      lat = 0;
      while (!m_valid && lat < 10) begin @(posedge clk); #1; lat++; end
      clear = 1'b1; m_ready = 1'b1;
      step(1);
      clear = 1'b0;
      drain();
      check_eq("clr_hs_data", 64'(last_data), 64'h007F0000);
      check_eq("clr_hs_sticky", 64'(ovf_sticky), 64'h4);
      check_eq("clr_hs_count", 64'(sat_count), 64'd1);

      // full pipeline stalled for five cycles
      n0 = n_out;
      m_ready = 1'b0;
      fork
         begin
            for (int i = 0; i < LAT + 1; i++) send_beat(6'($urandom), $urandom, $urandom);
         end
         begin
            lat = 0;
            while (!m_valid && lat < 20) begin @(posedge clk); #1; lat++; end
            repeat (5) begin
               @(posedge clk); #1;
               check_eq("stall_s_ready", 64'(s_ready), 64'(0));
            end
            m_ready = 1'b1;
         end
      join
      drain();
      check_eq("stall_beats_out", 64'(n_out - n0), 64'(LAT + 1));

      // clock enable low mid-stream
      fork
         begin
            for (int i = 0; i < 6; i++) send_beat(6'($urandom), $urandom, $urandom);
         end
         begin
            step(2); cke = 1'b0; step(3); cke = 1'b1;
         end
      join
      drain();

      // mixed random beats with random back-pressure
      fork
         begin
            for (int i = 0; i < 60; i++) send_beat(6'($urandom), $urandom, $urandom);
         end
         begin
            repeat (150) begin
               @(posedge clk); #1;
               m_ready = ($urandom_range(0, 3) != 0);
            end
            m_ready = 1'b1;
         end
      join
      m_ready = 1'b1;
      drain();

      // reset with two beats in flight
      n0 = n_out;
      send_beat(6'b01_0_001, {4{8'h80}}, {4{8'h01}});
      send_beat(6'b01_0_001, {4{8'h80}}, {4{8'h01}});
      reset = 1'b0;
      #1;
      check_eq("midrst_m_valid", 64'(m_valid), 64'(0));
      check_eq("midrst_count", 64'(sat_count), 64'(0));
      check_eq("midrst_s_ready", 64'(s_ready), 64'(0));
      step(1);
      reset = 1'b1;
      step(6);
      check_eq("midrst_no_stale", 64'(n_out - n0), 64'(0));
      check_eq("midrst_m_valid_after", 64'(m_valid), 64'(0));

      // counter saturates at all-ones
      for (int i = 0; i < 65540; i++) send_beat(6'b01_0_001, {4{8'h80}}, {4{8'h01}});
      drain();
      check_eq("count_saturated", 64'(sat_count), 64'hFFFF);
      check_eq("count_sticky", 64'(ovf_sticky), 64'hF);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/spu_addsub_pipe.md
SPU_ADDSUB_PIPE -- requirements
Module: spu_addsub_pipe

Interface
REQ-001 SHALL have parameter LANES, default 4: number of independent arithmetic lanes, 1..16.
REQ-002 SHALL have parameter DATA_BITS, default 8: width of each lane operand, 2..64.
REQ-003 SHALL have parameter LATENCY, default 2: pipeline register stages from input handshake to output, 1..4.
REQ-004 SHALL have parameter COUNT_BITS, default 16: width of the saturation event counter.
REQ-005 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-low reset (asserted at 0).
REQ-007 SHALL have port cke  input  1  clock enable; 0 freezes all state.
REQ-008 SHALL have port s_cfg  input  6  per-beat op: [2:0] opcode, [3] carry-in, [5:4] saturation mode.
REQ-009 SHALL have port s_data0  input  LANES*DATA_BITS  operand a, lane i at bits [i*DATA_BITS +: DATA_BITS].
REQ-010 SHALL have port s_data1  input  LANES*DATA_BITS  operand b, same packing.
REQ-011 SHALL have port s_valid / s_ready  input / output  1 each  input handshake.
REQ-012 SHALL have port m_data  output  LANES*DATA_BITS  per-lane results.
REQ-013 SHALL have port m_carry / m_ovf  output  LANES each  per-lane unsigned-range / signed-range exceeded flags.
REQ-014 SHALL have port m_valid / m_ready  output / input  1 each  output handshake.
REQ-015 SHALL have port clear  input  1  synchronous clear of sticky flags and counter.
REQ-016 SHALL have port ovf_sticky  output  LANES  per-lane sticky overflow; sat_count  output  COUNT_BITS  saturated-beat count.

Function
REQ-017 SHALL compute the exact result r per lane in DATA_BITS+3 bits, signed for signed mode, else unsigned: opcode 0 a+b, 1 a-b, 2 a-1, 3 a+1, 4 a+a, 5 a-a, 6 a+2b, 7 a-2b, then r += s_cfg[3].
REQ-018 SHALL set m_carry[i] when r lies outside [0, 2^DATA_BITS-1] (a, b unsigned) and m_ovf[i] when r lies outside [-2^(DATA_BITS-1), 2^(DATA_BITS-1)-1] (a, b signed), independent of mode.
REQ-019 SHALL output, per mode: 00 wrap (low DATA_BITS of r); 01 signed saturate to 0x7F.. / 0x80..; 10 unsigned saturate to all-ones / zero; 11 treated as 00.
REQ-020 SHALL define stall = m_valid && !m_ready; pipeline advance = cke && !stall; s_ready = advance.
REQ-021 SHALL accept a beat on an edge where s_valid && s_ready, and present it on m_data with m_valid=1 exactly LATENCY advancing edges later (LATENCY=1: visible right after the accepting edge).
REQ-022 SHALL carry valid bits with data through every stage; bubbles propagate and are not collapsed.
REQ-023 SHALL hold m_data, m_carry, m_ovf and m_valid stable while stalled or cke=0; no beat lost or duplicated.
REQ-024 SHALL set ovf_sticky[i] on an output handshake (m_valid && m_ready && cke) whose m_ovf[i]=1; set has priority over a simultaneous clear.
REQ-025 SHALL increment sat_count by one per output handshake in which any lane was clamped by saturation (mode 01/10), saturating at all-ones without wrap.
REQ-026 SHALL apply clear only when cke=1; clear with a simultaneous saturated handshake yields sat_count=1.
REQ-027 SHALL make s_cfg per-beat; mixed opcodes in consecutive beats each complete with their own cfg.

Reset
REQ-028 SHALL on reset=0 asynchronously clear all stage valid bits, m_valid, m_data, m_carry, m_ovf, ovf_sticky, sat_count to 0; s_ready=0 while reset=0.
REQ-029 SHALL discard in-flight beats on reset assertion mid-operation; after release first m_valid only follows a new accepted beat.

Verification
REQ-030 SHALL cover: DATA_BITS=8, op0 wrap, a=0xF0 b=0x20 -> m_data=0x10, m_carry=1, m_ovf=0, after LATENCY edges.
REQ-031 SHALL cover: op1 signed sat, a=0x80 b=0x01 -> m_data=0x80, m_ovf=1, sat_count=1, ovf_sticky[lane]=1.
REQ-032 SHALL cover: op7 unsigned sat, a=0x05 b=0x03, cin=1 -> r=-0 ... a-6+1=0 -> m_data=0x00, no clamp; a=0x02 same -> m_data=0x00, m_carry=1, sat_count increments.
REQ-033 SHALL cover: m_ready=0 for 5 cycles with pipeline full -> s_ready=0, outputs frozen, all LATENCY+1 beats later emerge in order, none lost.
REQ-034 SHALL cover: reset pulse with 2 beats in flight -> m_valid=0 immediately, sat_count=0, no stale beat emerges after release.
REQ-035 SHALL cover: clear coincident with overflowing handshake -> ovf_sticky=1; sat_count held at 0xFFFF after 65536+ saturated beats (COUNT_BITS=16).
